// File: rtl/ram_sp_arb_pkg.sv
// Shared constants for the single-port RAM arbiter: FSM state encoding and requester ids.
package ram_sp_arb_pkg;

    localparam logic ST_SWEEP = 1'b1;
    localparam logic ST_SERVE = 1'b0;

    localparam logic REQ0 = 1'b0;
    localparam logic REQ1 = 1'b1;

    localparam int NUM_REQ = 2;

    typedef enum logic {
        SERVE = ST_SERVE,
        SWEEP = ST_SWEEP
    } state_e;

endpackage

// File: rtl/ram_sp_arb_rr.sv
// Two-input round-robin grant: one-hot grant, pointer moves to the loser after each grant.
module rr_arb2
    import ram_sp_arb_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic [1:0] valid,
    input  logic       enable,
    output logic [1:0] grant
);

    logic ptr;

    always_comb begin
        grant = 2'b00;
        if (enable) begin
            if (valid == 2'b11)
                grant = (ptr == REQ1) ? 2'b10 : 2'b01;
            else
                grant = valid;
        end
    end

    always_ff @(posedge clock) begin
        if (reset)
            ptr <= REQ0;
        else if (|grant)
            ptr <= grant[0] ? REQ1 : REQ0;
    end

endmodule

// File: rtl/ram_sp_arb.sv
// Round-robin sequencer for one single-port RAM with post-reset / on-demand init sweep.
// Define RAM_SP_ARB_PERF_EN to add the saturating conflict_cnt_out contention counter.
module ram_sp_arb
    import ram_sp_arb_pkg::*;
#(
    parameter int                  DATAWIDTH = 64,
    parameter int                  INDEXSIZE = 256,
    parameter int                  LOGINDEX  = 8,
    parameter logic [DATAWIDTH-1:0] INITVALUE = '0
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 clear_in,
    output logic                 busy_out,
    input  logic                 req0_valid_in,
    input  logic                 req0_we_in,
    input  logic [LOGINDEX-1:0]  req0_index_in,
    input  logic [DATAWIDTH-1:0] req0_data_in,
    output logic                 req0_ready_out,
    output logic                 rsp0_valid_out,
    output logic [DATAWIDTH-1:0] rsp0_data_out,
    input  logic                 req1_valid_in,
    input  logic                 req1_we_in,
    input  logic [LOGINDEX-1:0]  req1_index_in,
    input  logic [DATAWIDTH-1:0] req1_data_in,
    output logic                 req1_ready_out,
    output logic                 rsp1_valid_out,
    output logic [DATAWIDTH-1:0] rsp1_data_out,
    output logic                 ram_we_out,
    output logic [LOGINDEX-1:0]  ram_index_out,
    output logic [DATAWIDTH-1:0] ram_data_out,
    input  logic [DATAWIDTH-1:0] ram_rdata_in
`ifdef RAM_SP_ARB_PERF_EN
    ,
    output logic [31:0]          conflict_cnt_out
`endif
);

    localparam logic [LOGINDEX:0] SWEEP_LAST = (LOGINDEX+1)'(INDEXSIZE-1);
    localparam logic [LOGINDEX:0] CNT_ONE    = (LOGINDEX+1)'(1);

    state_e                                   state;
    logic [LOGINDEX:0]                        sweep_cnt;
    logic [NUM_REQ-1:0]                       req_valid, req_we, grant, rsp_vld;
    logic [NUM_REQ-1:0][LOGINDEX-1:0]         req_index;
    logic [NUM_REQ-1:0][DATAWIDTH-1:0]        req_data, rsp_data;
    logic                                     gid, arb_en;

    assign req_valid = {req1_valid_in, req0_valid_in};
    assign req_we    = {req1_we_in,    req0_we_in};
    assign req_index = {req1_index_in, req0_index_in};
    assign req_data  = {req1_data_in,  req0_data_in};

    // clear_in beats any request in the same cycle
    assign arb_en = !reset && (state == SERVE) && !clear_in;

    rr_arb2 u_arb (
        .clock  (clock),
        .reset  (reset),
        .valid  (req_valid),
        .enable (arb_en),
        .grant  (grant)
    );

    assign gid            = grant[1] ? REQ1 : REQ0;
    assign req0_ready_out = grant[0];
    assign req1_ready_out = grant[1];
    assign busy_out       = (state == SWEEP);

    always_comb begin
        ram_we_out    = 1'b0;
        ram_index_out = '0;
        ram_data_out  = '0;
        if (!reset) begin
            if (state == SWEEP) begin
                ram_we_out    = 1'b1;
                ram_index_out = sweep_cnt[LOGINDEX-1:0];
                ram_data_out  = INITVALUE;
            end else if (|grant) begin
                ram_we_out    = req_we[gid];
                ram_index_out = req_index[gid];
                ram_data_out  = req_data[gid];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= SWEEP;
            sweep_cnt <= '0;
            rsp_vld   <= '0;
            rsp_data  <= '0;
        end else begin
            rsp_vld <= grant & ~req_we;
            for (int i = 0; i < NUM_REQ; i++)
                if (grant[i] && !req_we[i])
                    rsp_data[i] <= ram_rdata_in;
            case (state)
                SWEEP: begin
                    sweep_cnt <= sweep_cnt + CNT_ONE;
                    if (sweep_cnt == SWEEP_LAST)
                        state <= SERVE;
                end
                default: begin
                    if (clear_in) begin
                        state     <= SWEEP;
                        sweep_cnt <= '0;
                    end
                end
            endcase
        end
    end

    assign rsp0_valid_out = rsp_vld[0];
    assign rsp1_valid_out = rsp_vld[1];
    assign rsp0_data_out  = rsp_data[0];
    assign rsp1_data_out  = rsp_data[1];

`ifdef RAM_SP_ARB_PERF_EN
    logic [31:0] conflict_cnt;

    always_ff @(posedge clock) begin
        if (reset)
            conflict_cnt <= '0;
        else if (state == SERVE && !clear_in && (&req_valid) && conflict_cnt != '1)
            conflict_cnt <= conflict_cnt + 32'd1;
    end

    assign conflict_cnt_out = conflict_cnt;
`endif

endmodule

// File: tb/tb_ram_sp_arb.sv
// Directed bench for ram_sp_arb: RAM behavioural model, per-cycle reference model, literal pins.
module tb_ram_sp_arb;

    localparam int DW = 64;
    localparam int N  = 256;
    localparam int LI = 8;
    localparam logic [DW-1:0] INIT = '0;

    logic          clock = 1'b0;
    logic          reset, clear_in, busy_out;
    logic          req0_valid_in, req0_we_in, req0_ready_out, rsp0_valid_out;
    logic          req1_valid_in, req1_we_in, req1_ready_out, rsp1_valid_out;
    logic [LI-1:0] req0_index_in, req1_index_in, ram_index_out;
    logic [DW-1:0] req0_data_in, req1_data_in, rsp0_data_out, rsp1_data_out;
    logic          ram_we_out;
    logic [DW-1:0] ram_data_out, ram_rdata_in;
`ifdef RAM_SP_ARB_PERF_EN
    logic [31:0]   conflict_cnt_out;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    ram_sp_arb #(.DATAWIDTH(DW), .INDEXSIZE(N), .LOGINDEX(LI), .INITVALUE(INIT)) dut (
        .clock(clock), .reset(reset), .clear_in(clear_in), .busy_out(busy_out),
        .req0_valid_in(req0_valid_in), .req0_we_in(req0_we_in), .req0_index_in(req0_index_in),
        .req0_data_in(req0_data_in), .req0_ready_out(req0_ready_out),
        .rsp0_valid_out(rsp0_valid_out), .rsp0_data_out(rsp0_data_out),
        .req1_valid_in(req1_valid_in), .req1_we_in(req1_we_in), .req1_index_in(req1_index_in),
        .req1_data_in(req1_data_in), .req1_ready_out(req1_ready_out),
        .rsp1_valid_out(rsp1_valid_out), .rsp1_data_out(rsp1_data_out),
        .ram_we_out(ram_we_out), .ram_index_out(ram_index_out), .ram_data_out(ram_data_out),
        .ram_rdata_in(ram_rdata_in)
`ifdef RAM_SP_ARB_PERF_EN
        , .conflict_cnt_out(conflict_cnt_out)
`endif
    );

    // The physical RAM the arbiter fronts
    logic [DW-1:0] mem [N];
    initial for (int i = 0; i < N; i++) mem[i] = '0;
    always @(posedge clock) if (ram_we_out) mem[ram_index_out] <= ram_data_out;
    assign ram_rdata_in = mem[ram_index_out];

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: intended RAM contents, sweep position, rr owner, pending responses
    logic [DW-1:0] ref_mem [N];
    logic [DW-1:0] m_rd [2];
    logic [1:0]    m_rv;
    bit            m_known = 0, m_sweep;
    int            m_cnt, m_ptr, g;
    longint        m_conf;
    logic [1:0]    v, rwe;
    logic [LI-1:0] ridx [2];
    logic [DW-1:0] rdat [2];

    always @(negedge clock) begin
        v = {req1_valid_in, req0_valid_in};
        rwe = {req1_we_in, req0_we_in};
        ridx[0] = req0_index_in; ridx[1] = req1_index_in;
        rdat[0] = req0_data_in;  rdat[1] = req1_data_in;
        g = -1;
        if (reset) begin
            chk("reset_ram_we", ram_we_out, 0);
            chk("reset_ready", {req1_ready_out, req0_ready_out}, 0);
        end else if (m_known) begin
            chk("busy", busy_out, m_sweep);
            chk("rsp0_valid", rsp0_valid_out, m_rv[0]);
            chk("rsp1_valid", rsp1_valid_out, m_rv[1]);
            chk("rsp0_data", rsp0_data_out, m_rd[0]);
            chk("rsp1_data", rsp1_data_out, m_rd[1]);
`ifdef RAM_SP_ARB_PERF_EN
            chk("conflict_cnt", conflict_cnt_out, m_conf);
`endif
            if (m_sweep) begin
                chk("sweep_we", ram_we_out, 1);
                chk("sweep_idx", ram_index_out, m_cnt);
                chk("sweep_data", ram_data_out, INIT);
                chk("sweep_ready", {req1_ready_out, req0_ready_out}, 0);
            end else begin
                if (!clear_in) begin
                    if (v == 2'b11) g = m_ptr;
                    else if (v[0]) g = 0;
                    else if (v[1]) g = 1;
                end
                if (g < 0) begin
                    chk("idle_ready", {req1_ready_out, req0_ready_out}, 0);
                    chk("idle_we", ram_we_out, 0);
                    chk("idle_idx", ram_index_out, 0);
                end else begin
                    chk("grant_ready", {req1_ready_out, req0_ready_out}, (g == 1) ? 2'b10 : 2'b01);
                    chk("grant_we", ram_we_out, rwe[g]);
                    chk("grant_idx", ram_index_out, ridx[g]);
                    chk("grant_data", ram_data_out, rdat[g]);
                end
            end
        end
        // advance the model across the coming rising edge
        if (reset) begin
            m_known = 1; m_sweep = 1; m_cnt = 0; m_ptr = 0; m_rv = '0;
            m_rd[0] = '0; m_rd[1] = '0; m_conf = 0;
        end else if (m_known) begin
            m_rv = '0;
            if (m_sweep) begin
                ref_mem[m_cnt] = INIT;
                m_cnt++;
                if (m_cnt == N) m_sweep = 0;
            end else if (clear_in) begin
                m_sweep = 1; m_cnt = 0;
            end else begin
                if (v == 2'b11 && m_conf < 64'hFFFF_FFFF) m_conf++;
                if (g >= 0) begin
                    m_ptr = 1 - g;
                    if (rwe[g]) ref_mem[ridx[g]] = rdat[g];
                    else begin m_rv[g] = 1'b1; m_rd[g] = ref_mem[ridx[g]]; end
                end
            end
        end
    end

    task automatic step();
        @(posedge clock); #1;
    endtask

    task automatic idle();
        req0_valid_in = 0; req0_we_in = 0; req0_index_in = '0; req0_data_in = '0;
        req1_valid_in = 0; req1_we_in = 0; req1_index_in = '0; req1_data_in = '0;
        clear_in = 0;
    endtask

    task automatic count_sweep(input string name);
        int n = 0;
        while (busy_out && n < 400) begin n++; step(); end
        chk(name, n, N);
    endtask

    logic [5:0] gs;

    initial begin
        reset = 1; idle();
        repeat (2) @(posedge clock);
        #1 reset = 0;
        chk("first_sweep_idx", ram_index_out, 0);
        count_sweep("sweep_len_after_reset");

        // write idx 5 from req0, then read it back on req1
        req0_valid_in = 1; req0_we_in = 1; req0_index_in = 8'd5; req0_data_in = 64'hA5A5;
        #1 chk("wr_ready0", req0_ready_out, 1);
        step();
        req0_valid_in = 0; req1_valid_in = 1; req1_we_in = 0; req1_index_in = 8'd5;
        #1 chk("rd_ready1", req1_ready_out, 1);
        step();
        req1_valid_in = 0;
        chk("rd_rsp1_valid", rsp1_valid_out, 1);
        chk("rd_rsp1_data", rsp1_data_out, 64'hA5A5);
        chk("rd_rsp0_quiet", rsp0_valid_out, 0);
        step();
        chk("rsp1_one_pulse", rsp1_valid_out, 0);

        // continuous contention: grants must alternate starting with req0
        req0_valid_in = 1; req0_we_in = 0; req0_index_in = 8'd5;
        req1_valid_in = 1; req1_we_in = 0; req1_index_in = 8'd6;
        for (int i = 0; i < 6; i++) begin
            #1 gs[i] = req1_ready_out;
            step();
        end
        chk("rr_sequence", gs, 6'b101010);
        chk("rr_last_rsp1", rsp1_valid_out, 1);
        chk("rr_last_rsp1_data", rsp1_data_out, 0);

        // clear beats a pending request, then req0 wins the first SERVE cycle
        req1_valid_in = 0; clear_in = 1;
        #1 chk("clear_no_ready", req0_ready_out, 0);
        step();
        clear_in = 0;
        count_sweep("sweep_len_after_clear");
        #1 chk("post_clear_ready0", req0_ready_out, 1);
        step();
        idle();
        chk("post_clear_rsp0_valid", rsp0_valid_out, 1);
        chk("post_clear_rsp0_data", rsp0_data_out, 0);

        // reset in the middle of a sweep restarts it from index 0
        step();
        clear_in = 1; step(); clear_in = 0;
        repeat (100) step();
        chk("mid_sweep_idx100", ram_index_out, 100);
        reset = 1; step(); reset = 0;
        chk("restart_idx0", ram_index_out, 0);
        count_sweep("sweep_len_after_midreset");

`ifdef RAM_SP_ARB_PERF_EN
        req0_valid_in = 1; req1_valid_in = 1; req1_index_in = 8'd1;
        repeat (10) step();
        req1_valid_in = 0;
        repeat (5) step();
        idle(); step();
        chk("conflict_cnt_10", conflict_cnt_out, 10);
`endif
        idle();
        repeat (3) step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
